lelo_temp_counter: RTL

//  Multi-channel digital readout for lelo temperature-sensor oscillators. Scans
//  NCH sync'd oscillator inputs round-robin, counts rising edges of each over a

---
 rtl/lelo_temp_counter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/lelo_temp_counter.sv
// Multi-channel edge counter for lelo temperature-sensor oscillators.
// Masked channels are scanned round-robin and one saturating count per window is returned over valid/ready.
module lelo_temp_counter #(
  parameter int NCH    = 4,
  parameter int CW     = 16,
  parameter int WW     = 16,
  parameter int SETTLE = 4,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           start,
  input  logic           cont,
  input  logic [NCH-1:0] ch_mask,
  input  logic [WW-1:0]  win_len,
  input  logic [NCH-1:0] osc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CW-1:0]  out_data,
  output logic [CHW-1:0] out_ch,
  output logic           out_sat,
  output logic           busy
);
  localparam int STW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0]  CNT_MAX     = {CW{1'b1}};
  localparam logic [STW-1:0] SETTLE_LOAD = STW'(SETTLE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_COUNT, ST_DONE} state_t;

  state_t         state_reg, state_next;
  logic [NCH-1:0] mask_reg, mask_next;
  logic [WW-1:0]  win_reg, win_next;
  logic [CHW-1:0] sel_reg, sel_next;
  logic [STW-1:0] settle_reg, settle_next;
  logic [WW-1:0]  wcnt_reg, wcnt_next;
  logic [CW-1:0]  count_reg, count_next;
  logic           sat_reg, sat_next;
  logic [CW-1:0]  data_reg, data_next;
  logic [CHW-1:0] ch_reg, ch_next;
  logic           osat_reg, osat_next;

  logic [NCH-1:0] edge_vec;
  logic           sel_edge;
  logic [WW-1:0]  win_eff;
  logic [CW-1:0]  cnt_upd;
  logic           sat_upd;
  logic           higher_found;
  logic [CHW-1:0] higher_ch;

  // Per-channel two-flop synchroniser plus a history flop for rising-edge detection.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_sync
      logic s1_reg, s2_reg, s3_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
          s3_reg <= 1'b0;
        end else begin
          s1_reg <= osc[gi];
          s2_reg <= s1_reg;
          s3_reg <= s2_reg;
        end
      end
      assign edge_vec[gi] = s2_reg & ~s3_reg;
    end
  endgenerate

  assign sel_edge = edge_vec[sel_reg];
  assign win_eff  = (win_reg == '0) ? WW'(1) : win_reg;

  function automatic logic [CHW-1:0] lowest_bit(input logic [NCH-1:0] m);
    lowest_bit = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (m[i]) lowest_bit = CHW'(i);
  endfunction

  always_comb begin
    higher_found = 1'b0;
    higher_ch    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_reg[i] && (i > int'(sel_reg))) begin
        higher_found = 1'b1;
        higher_ch    = CHW'(i);
      end
    end
  end

  // An edge at full scale leaves the count pinned and flags the overflow instead.
  always_comb begin
    cnt_upd = count_reg;
    sat_upd = sat_reg;
    if (sel_edge) begin
      if (count_reg == CNT_MAX) sat_upd = 1'b1;
      else                      cnt_upd = count_reg + 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mask_next   = mask_reg;
    win_next    = win_reg;
    sel_next    = sel_reg;
    settle_next = settle_reg;
    wcnt_next   = wcnt_reg;
    count_next  = count_reg;
    sat_next    = sat_reg;
    data_next   = data_reg;
    ch_next     = ch_reg;
    osat_next   = osat_reg;

    if (!en && (state_reg != ST_IDLE)) begin
      // Abort discards the measurement in flight; the last result stays on out_data.
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (en && start && (ch_mask != '0)) begin
            mask_next   = ch_mask;
            win_next    = win_len;
            sel_next    = lowest_bit(ch_mask);
            settle_next = SETTLE_LOAD;
            state_next  = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          count_next = '0;
          sat_next   = 1'b0;
          if (settle_reg == '0) begin
            wcnt_next  = win_eff - 1'b1;
            state_next = ST_COUNT;
          end else begin
            settle_next = settle_reg - 1'b1;
          end
        end
        ST_COUNT: begin
          count_next = cnt_upd;
          sat_next   = sat_upd;
          if (wcnt_reg == '0) begin
            data_next  = cnt_upd;
            ch_next    = sel_reg;
            osat_next  = sat_upd;
            state_next = ST_DONE;
          end else begin
            wcnt_next = wcnt_reg - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            if (higher_found) begin
              sel_next    = higher_ch;
              settle_next = SETTLE_LOAD;
              state_next  = ST_SETTLE;
            end else if (cont) begin
              mask_next = ch_mask;
              win_next  = win_len;
              if (ch_mask != '0) begin
                sel_next    = lowest_bit(ch_mask);
                settle_next = SETTLE_LOAD;
                state_next  = ST_SETTLE;
              end else begin
                state_next = ST_IDLE;
              end
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      mask_reg   <= '0;
      win_reg    <= '0;
      sel_reg    <= '0;
      settle_reg <= '0;
      wcnt_reg   <= '0;
      count_reg  <= '0;
      sat_reg    <= 1'b0;
      data_reg   <= '0;
      ch_reg     <= '0;
      osat_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mask_reg   <= mask_next;
      win_reg    <= win_next;
      sel_reg    <= sel_next;
      settle_reg <= settle_next;
      wcnt_reg   <= wcnt_next;
      count_reg  <= count_next;
      sat_reg    <= sat_next;
      data_reg   <= data_next;
      ch_reg     <= ch_next;
      osat_reg   <= osat_next;
    end
  end

  assign out_valid = (state_reg == ST_DONE);
  assign busy      = (state_reg != ST_IDLE);
  assign out_data  = data_reg;
  assign out_ch    = ch_reg;
  assign out_sat   = osat_reg;

endmodule
